// File: rtl/regwb_pkg.sv
// Shared widths and requester indices for the register-file write-back arbiter.
package regwb_pkg;
    localparam int REG_ADDR_LEN = 5;
    localparam int REG_LENGTH   = 32;
    localparam int REG_NUM      = 32;
    localparam int WB_NUM_REQ   = 3;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MDU  = 2;
endpackage

// File: rtl/wb_req_buf.sv
// One-entry write-back buffer per requester; fills in the edge after a handshake.
// A load in the same cycle as its pop keeps the buffer full, which sustains one write per cycle.
module wb_req_buf
    import regwb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    pop,
    input  logic [REG_ADDR_LEN-1:0] inAddr,
    input  logic [REG_LENGTH-1:0]   inData,
    output logic                    full,
    output logic [REG_ADDR_LEN-1:0] addr,
    output logic [REG_LENGTH-1:0]   data
);
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            addr <= inAddr;
            data <= inData;
        end else if (pop) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates three write-back requesters onto one registered RegFile write port, 1-cycle buffer-to-we latency.
// Ready is high when a requester's buffer is empty or being drained; WB_ARB_RR_EN selects round-robin over fixed priority.
module regfile_wb_arbiter
    import regwb_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [WB_NUM_REQ-1:0]              reqValid,
    input  logic [WB_NUM_REQ*REG_ADDR_LEN-1:0] reqAddr,
    input  logic [WB_NUM_REQ*REG_LENGTH-1:0]   reqData,
    output logic [WB_NUM_REQ-1:0]              reqReady,
    output logic                               we,
    output logic [REG_ADDR_LEN-1:0]            wAddr,
    output logic [REG_LENGTH-1:0]              wData,
    output logic [REG_NUM-1:0]                 busyMask
);
    logic [WB_NUM_REQ-1:0]   full;
    logic [WB_NUM_REQ-1:0]   grant;
    logic [WB_NUM_REQ-1:0]   xfer;
    logic [REG_ADDR_LEN-1:0] bufAddr [WB_NUM_REQ];
    logic [REG_LENGTH-1:0]   bufData [WB_NUM_REQ];
    logic [REG_ADDR_LEN-1:0] gAddr;
    logic [REG_LENGTH-1:0]   gData;

    assign reqReady = rst ? '0 : (~full | grant);
    assign xfer     = reqValid & reqReady;

    for (genvar i = 0; i < WB_NUM_REQ; i++) begin : g_buf
        wb_req_buf u_buf (
            .clk    (clk),
            .rst    (rst),
            .load   (xfer[i]),
            .pop    (grant[i]),
            .inAddr (reqAddr[i*REG_ADDR_LEN +: REG_ADDR_LEN]),
            .inData (reqData[i*REG_LENGTH +: REG_LENGTH]),
            .full   (full[i]),
            .addr   (bufAddr[i]),
            .data   (bufData[i])
        );
    end

`ifdef WB_ARB_RR_EN
    logic [1:0] lastGrant;
    logic [1:0] grantIdx;
    logic [1:0] cand;

    // Walk candidates from farthest to nearest so the nearest full buffer after lastGrant wins.
    always_comb begin
        grant    = '0;
        grantIdx = lastGrant;
        cand     = lastGrant;
        for (int k = WB_NUM_REQ; k >= 1; k--) begin
            cand = 2'((int'(lastGrant) + k) % WB_NUM_REQ);
            if (full[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grantIdx    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant <= 2'(REQ_MDU);
        end else if (|grant) begin
            lastGrant <= grantIdx;
        end
    end
`else
    localparam logic [WB_NUM_REQ-1:0] ONE = 1;

    // Isolate the lowest set bit: requester 0 has highest priority.
    always_comb grant = full & (~full + ONE);
`endif

    always_comb begin
        gAddr = '0;
        gData = '0;
        for (int i = 0; i < WB_NUM_REQ; i++) begin
            if (grant[i]) begin
                gAddr = gAddr | bufAddr[i];
                gData = gData | bufData[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            wAddr <= '0;
            wData <= '0;
        end else if (|grant) begin
            we    <= (gAddr != '0);
            wAddr <= gAddr;
            wData <= gData;
        end else begin
            we <= 1'b0;
        end
    end

    // $0 never counts as busy since writes to it are dropped.
    always_comb begin
        busyMask = '0;
        for (int i = 0; i < WB_NUM_REQ; i++) begin
            if (full[i]) busyMask[bufAddr[i]] = 1'b1;
        end
        if (we) busyMask[wAddr] = 1'b1;
        busyMask[0] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs driven and outputs sampled 1ns after each rising edge.
module tb_regfile_wb_arbiter;
    import regwb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  reqValid;
    logic [14:0] reqAddr;
    logic [95:0] reqData;
    logic [2:0]  reqReady;
    logic        we;
    logic [4:0]  wAddr;
    logic [31:0] wData;
    logic [31:0] busyMask;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .reqAddr  (reqAddr),
        .reqData  (reqData),
        .reqReady (reqReady),
        .we       (we),
        .wAddr    (wAddr),
        .wData    (wData),
        .busyMask (busyMask)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        reqAddr[i*5 +: 5]  = a;
        reqData[i*32 +: 32] = d;
    endtask

    task automatic check_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        check_val({tag, "_we"}, 32'(we), 32'd1);
        check_val({tag, "_addr"}, 32'(wAddr), 32'(a));
        check_val({tag, "_data"}, wData, d);
    endtask

    initial begin
        rst      = 1'b1;
        reqValid = 3'b000;
        reqAddr  = '0;
        reqData  = '0;
        step();
        reqValid = 3'b111;
        step();
        check_val("rst_we", 32'(we), 32'd0);
        check_val("rst_waddr", 32'(wAddr), 32'd0);
        check_val("rst_wdata", wData, 32'd0);
        check_val("rst_ready_low", 32'(reqReady), 32'd0);
        check_val("rst_busy", busyMask, 32'd0);
        reqValid = 3'b000;
        rst      = 1'b0;
        #1;
        check_val("post_rst_ready", 32'(reqReady), 32'b111);
        check_val("post_rst_busy", busyMask, 32'd0);

        // Contention: three requesters at once, written 1,2,3.
        set_req(REQ_ALU, 5'd1, 32'hAAAA_0001);
        set_req(REQ_LOAD, 5'd2, 32'hBBBB_0002);
        set_req(REQ_MDU, 5'd3, 32'hCCCC_0003);
        reqValid = 3'b111;
        step();
        reqValid = 3'b000;
        check_val("cont_ready0", 32'(reqReady), 32'b001);
        check_val("cont_busy0", busyMask, 32'h0000_000E);
        check_val("cont_we0", 32'(we), 32'd0);
        step();
        check_wr("cont_w1", 5'd1, 32'hAAAA_0001);
        check_val("cont_ready1", 32'(reqReady), 32'b011);
        check_val("cont_busy1", busyMask, 32'h0000_000E);
        step();
        check_wr("cont_w2", 5'd2, 32'hBBBB_0002);
        check_val("cont_ready2", 32'(reqReady), 32'b111);
        check_val("cont_busy2", busyMask, 32'h0000_000C);
        step();
        check_wr("cont_w3", 5'd3, 32'hCCCC_0003);
        check_val("cont_busy3", busyMask, 32'h0000_0008);
        step();
        check_val("cont_idle_we", 32'(we), 32'd0);

        // Same address from ALU and MDU: both writes kept, ALU first.
        set_req(REQ_ALU, 5'd7, 32'h0000_0011);
        set_req(REQ_MDU, 5'd7, 32'h0000_0022);
        reqValid = 3'b101;
        step();
        reqValid = 3'b000;
        check_val("same_busy", busyMask, 32'h0000_0080);
        check_val("same_ready", 32'(reqReady), 32'b011);
        step();
        check_wr("same_w1", 5'd7, 32'h0000_0011);
        step();
        check_wr("same_w2", 5'd7, 32'h0000_0022);
        step();
        check_val("same_idle_we", 32'(we), 32'd0);

        // Single ALU write.
        set_req(REQ_ALU, 5'd5, 32'h0000_1234);
        reqValid = 3'b001;
        check_val("single_ready", 32'(reqReady), 32'b111);
        step();
        reqValid = 3'b000;
        check_val("single_we0", 32'(we), 32'd0);
        check_val("single_busy0", busyMask, 32'h0000_0020);
        step();
        check_wr("single_w", 5'd5, 32'h0000_1234);
        check_val("single_busy1", busyMask, 32'h0000_0020);
        step();
        check_val("single_we2", 32'(we), 32'd0);
        check_val("single_busy2", busyMask, 32'd0);
        check_val("single_hold", 32'(wAddr), 32'd5);

        // $0 write from LOAD is accepted and dropped.
        set_req(REQ_LOAD, 5'd0, 32'hFFFF_FFFF);
        reqValid = 3'b010;
        check_val("zero_ready", 32'(reqReady), 32'b111);
        step();
        reqValid = 3'b000;
        check_val("zero_busy0", busyMask, 32'd0);
        step();
        check_val("zero_we1", 32'(we), 32'd0);
        check_val("zero_busy1", busyMask, 32'd0);
        check_val("zero_ready1", 32'(reqReady), 32'b111);
        step();
        check_val("zero_we2", 32'(we), 32'd0);

        // Back-to-back ALU writes to 8..11.
        for (int k = 0; k < 4; k++) begin
            set_req(REQ_ALU, 5'(8 + k), 32'h100 + 32'(k));
            reqValid = 3'b001;
            check_val("b2b_ready", 32'(reqReady[0]), 32'd1);
            step();
            if (k > 0) check_wr("b2b_w", 5'(7 + k), 32'h100 + 32'(k - 1));
        end
        reqValid = 3'b000;
        step();
        check_wr("b2b_last", 5'd11, 32'h103);
        step();
        check_val("b2b_idle_we", 32'(we), 32'd0);

        // Reset with all three buffers full drops every pending write.
        set_req(REQ_ALU, 5'd4, 32'h4);
        set_req(REQ_LOAD, 5'd5, 32'h5);
        set_req(REQ_MDU, 5'd6, 32'h6);
        reqValid = 3'b111;
        step();
        reqValid = 3'b000;
        check_val("mid_busy", busyMask, 32'h0000_0070);
        rst = 1'b1;
        #1;
        check_val("mid_ready_rst", 32'(reqReady), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check_val("mid_we0", 32'(we), 32'd0);
        check_val("mid_ready", 32'(reqReady), 32'b111);
        check_val("mid_busy0", busyMask, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("mid_we", 32'(we), 32'd0);
        end

`ifdef WB_ARB_RR_EN
        // Round-robin with all requesters continuously valid: addresses 1,2,3 repeat.
        reqValid = 3'b111;
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 3; i++) set_req(i, 5'(i + 1), 32'(k * 16 + i));
            step();
            if (k > 0) begin
                check_val("rr_we", 32'(we), 32'd1);
                check_val("rr_addr", 32'(wAddr), 32'(((k - 1) % 3) + 1));
            end
        end
        reqValid = 3'b000;
        for (int k = 0; k < 4; k++) step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL expose: clk  input  1  single clock, all state updates on its rising edge.
REQ-002 The block SHALL expose: rst  input  1  reset, synchronous, active-high.
REQ-003 The block SHALL expose: reqValid  input  3  per-requester write request (0=ALU, 1=LOAD, 2=MDU).
REQ-004 The block SHALL expose: reqAddr  input  3x5  per-requester destination register address.
REQ-005 The block SHALL expose: reqData  input  3x32  per-requester write data.
REQ-006 The block SHALL expose: reqReady  output  3  per-requester accept indication.
REQ-007 The block SHALL expose: we, wAddr, wData  output  1/5/32  registered RegFile write port.
REQ-008 The block SHALL expose: busyMask  output  32  registers with a write pending, for hazard detection.

Function
REQ-009 Each requester SHALL own a one-entry buffer: valid bit, 5-bit addr, 32-bit data.
REQ-010 A transfer SHALL occur at a rising edge when reqValid[i] and reqReady[i] are both high; the buffer captures reqAddr[i]/reqData[i].
REQ-011 reqReady[i] SHALL be combinational: (buffer i empty) OR (grant[i] this cycle), forced low while rst is high.
REQ-012 Each cycle exactly one full buffer, or none, SHALL be granted; grant[i] empties buffer i at the next edge unless a new transfer refills it in the same cycle.
REQ-013 On grant, the output register SHALL load wAddr/wData from the granted buffer, with we=1 if addr!=0 and we=0 if addr==0 (write to $0 consumed silently).
REQ-014 With no grant, we SHALL be 0 at the next edge and wAddr/wData SHALL hold.
REQ-015 Latency SHALL be: transfer at edge N, uncontended grant in cycle N..N+1, we high from edge N+1; sustained throughput of one write per cycle in total.
REQ-016 busyMask SHALL be the OR of one-hot(addr) over full buffers and one-hot(wAddr) when we=1; bit 0 SHALL always be 0.
REQ-017 Simultaneous full buffers with the same address SHALL be written in grant order; the block SHALL NOT merge or reorder them otherwise.
REQ-018 A fixed-priority arbiter SHALL grant the lowest full index (0 highest) when WB_ARB_RR_EN is undefined.

Reset
REQ-019 While rst is high at an edge: all buffers empty, we=0, wAddr=0, wData=0, round-robin pointer=2; reqValid ignored.
REQ-020 Reset mid-operation SHALL discard all buffered and in-flight writes; none SHALL reach we after rst deasserts.
REQ-021 After reset, busyMask SHALL be all zeros and reqReady all ones in the first cycle with rst low.

Configuration
REQ-022 Macro WB_ARB_RR_EN defined: round-robin arbitration; search starts at (lastGrant+1) mod 3; lastGrant updates on every grant.
REQ-023 Macro WB_ARB_RR_EN undefined: fixed priority per REQ-018; no pointer register is instantiated.

Structure
REQ-024 A shared package regwb_pkg SHALL hold REG_ADDR_LEN=5, REG_LENGTH=32, REG_NUM=32, WB_NUM_REQ=3 and the requester index constants.
REQ-025 The per-requester buffer SHALL be a sub-module wb_req_buf, instantiated WB_NUM_REQ times; arbitration and output register stay in the top.

Verification
REQ-026 Single request: ALU valid addr=5 data=0x1234 for one cycle -> we=1, wAddr=5, wData=0x1234 exactly one cycle, starting one edge after the transfer; busyMask bit5 set from the transfer edge until we drops.
REQ-027 Contention, fixed priority: all three valid same cycle, addrs 1/2/3 -> writes in order 1,2,3 on three consecutive cycles; reqReady[2] low while its buffer waits.
REQ-028 Round-robin (WB_ARB_RR_EN): all three valid continuously with changing data -> grant sequence 0,1,2,0,1,2; no requester waits more than 2 cycles.
REQ-029 $0 write: LOAD addr=0 data=0xFFFFFFFF -> reqReady handshake completes, we stays 0, busyMask stays 0.
REQ-030 Reset mid-operation: three buffers full, assert rst one cycle -> we=0 in all following cycles until new requests; reqReady=3'b111 first cycle after rst low.
REQ-031 Back-to-back: ALU valid 4 consecutive cycles, addrs 8..11, no other requester -> we high 4 consecutive cycles with wAddr 8,9,10,11.
